// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce, edge-detect and chord-decode four push-buttons.
// Define AUTO_REPEAT_EN to compile in the per-button auto-repeat FSMs.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_DELAY    = 12500000,
   parameter int REPEAT_RATE     = 2500000,
   parameter int CHORD_HOLD      = 25000000
) (
   input  logic       i_Clk,
   input  logic       i_Reset_n,
   input  logic [3:0] i_Switch,
   output logic [3:0] o_Level,
   output logic [3:0] o_Press,
   output logic       o_Start,
   output logic       o_Reset_Game
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int CW = $clog2(CHORD_HOLD) + 1;
   logic [3:0] sync_a, sync_b, stable, stable_d, rise, pulse;
   logic [CW-1:0] hold_cnt;
   logic suppress, start_cond, start_d, all_held;
   assign o_Level    = stable;
   assign rise       = stable & ~stable_d;
   assign suppress   = $countones(stable) >= 3;
   assign start_cond = stable[2:0] == 3'b111 && !stable[3];
   assign all_held   = &stable;
   always_ff @(posedge i_Clk or negedge i_Reset_n)
      if (!i_Reset_n) begin
         sync_a       <= '0;
         sync_b       <= '0;
         stable_d     <= '0;
         start_d      <= 1'b0;
         hold_cnt     <= '0;
         o_Press      <= '0;
         o_Start      <= 1'b0;
         o_Reset_Game <= 1'b0;
      end else begin
         sync_a       <= i_Switch;
         sync_b       <= sync_a;
         stable_d     <= stable;
         start_d      <= start_cond;
         hold_cnt     <= !all_held ? '0 : hold_cnt == CW'(CHORD_HOLD) ? hold_cnt : hold_cnt + CW'(1);
         o_Press      <= suppress ? 4'b0000 : pulse;
         o_Start      <= start_cond && !start_d;
         o_Reset_Game <= all_held && hold_cnt == CW'(CHORD_HOLD - 1);
      end
   genvar n;
   generate
      for (n = 0; n < 4; n++) begin : g_ch
         logic [DW-1:0] cnt;
         logic stb;
         assign stable[n] = stb;
         always_ff @(posedge i_Clk or negedge i_Reset_n)
            if (!i_Reset_n) begin
               cnt <= '0;
               stb <= 1'b0;
            end else if (sync_b[n] == stb) begin
               cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
               cnt <= '0;
               stb <= sync_b[n];
            end else begin
               cnt <= cnt + DW'(1);
            end
`ifdef AUTO_REPEAT_EN
         localparam int TW = $clog2(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1;
         localparam logic [1:0] IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2;
         logic [1:0] state;
         logic [TW-1:0] timer;
         logic tick;
         assign tick = (state == DELAY && timer == TW'(REPEAT_DELAY - 1)) ||
                       (state == REPEAT && timer == TW'(REPEAT_RATE - 1));
         // a falling level masks a terminal count landing in the same cycle
         assign pulse[n] = rise[n] | (tick & stb);
         always_ff @(posedge i_Clk or negedge i_Reset_n)
            if (!i_Reset_n) begin
               state <= IDLE;
               timer <= '0;
            end else if (suppress || !stb) begin
               state <= IDLE;
               timer <= '0;
            end else if (rise[n]) begin
               state <= DELAY;
               timer <= '0;
            end else if (tick) begin
               state <= REPEAT;
               timer <= '0;
            end else if (state != IDLE) begin
               timer <= timer + TW'(1);
            end
`else
         assign pulse[n] = rise[n];
`endif
      end
   endgenerate
endmodule
